// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request, hazard/redirect controls and IF/ID outputs of the fetch stage
interface fetch_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  modport master (
    input  ihit, imemload, stall, flush, redirect, redirect_pc, halt,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );
  modport slave (
    output ihit, imemload, stall, flush, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID latch; FETCH_PERF_EN adds fetch_cnt/bubble_cnt counters
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD_REDIR, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_pc_q, pend_pc_d, instr_q, instr_d, npc_q, npc_d, pc_inc;
  logic        valid_q, valid_d, fetch_d, bubble_d;
  assign pc_inc        = pc_q + 32'd4;
  assign bus.imemaddr  = pc_q;
  assign bus.imemREN   = state_q != HALTED;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_npc   = npc_q;
  assign bus.ifid_valid = valid_q;
  // next state by priority: halt > redirect > stall > pending redirect > flush > hit > miss
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    npc_d     = npc_q;
    valid_d   = valid_q;
    fetch_d   = 1'b0;
    bubble_d  = 1'b0;
    if (state_q != HALTED) begin
      if (bus.halt) begin
        state_d  = HALTED;
        bubble_d = 1'b1;
      end else if (bus.redirect && !bus.stall) begin
        pc_d     = bus.redirect_pc;
        state_d  = FETCH;
        bubble_d = 1'b1;
      end else if (bus.redirect) begin
        pend_pc_d = bus.redirect_pc;
        state_d   = HOLD_REDIR;
      end else if (bus.stall) begin
      end else if (state_q == HOLD_REDIR) begin
        pc_d     = pend_pc_q;
        state_d  = FETCH;
        bubble_d = 1'b1;
      end else if (bus.ihit && !bus.flush) begin
        instr_d = bus.imemload;
        npc_d   = pc_inc;
        valid_d = 1'b1;
        pc_d    = pc_inc;
        fetch_d = 1'b1;
      end else begin
        pc_d     = (bus.flush && bus.ihit) ? pc_inc : pc_q;
        bubble_d = 1'b1;
      end
      if (bubble_d) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end
  end
  // PC, FSM state and IF/ID latch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      pend_pc_q <= 32'h0;
      instr_q   <= NOP_WORD;
      npc_q     <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      npc_q     <= npc_d;
      valid_q   <= valid_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  // saturating counts of captured instructions and inserted bubbles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (fetch_d && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble_d && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a behavioural fetch model
module tb_fetch_stage;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  fetch_if bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif
  fetch_stage dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc, m_pend, m_instr, m_npc, m_fc, m_bc;
  logic        m_valid, m_halted, m_pending;
  typedef struct {
    logic        ih;
    logic [31:0] ld;
    logic        st, fl, rd;
    logic [31:0] rp;
    logic        ht;
    logic [31:0] ea;
    logic        er;
    logic [31:0] ei, en;
    logic        ev;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic ih, logic [31:0] ld, logic st, logic fl, logic rd, logic [31:0] rp,
                              logic ht, logic [31:0] ea, logic er, logic [31:0] ei, logic [31:0] en, logic ev);
    vec_t r;
    r.ih = ih; r.ld = ld; r.st = st; r.fl = fl; r.rd = rd; r.rp = rp; r.ht = ht;
    r.ea = ea; r.er = er; r.ei = ei; r.en = en; r.ev = ev;
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic ih, logic [31:0] ld, logic st, logic fl, logic rd, logic [31:0] rp, logic ht);
    bus.ihit = ih; bus.imemload = ld; bus.stall = st; bus.flush = fl;
    bus.redirect = rd; bus.redirect_pc = rp; bus.halt = ht;
  endtask
  task automatic model_bubble();
    m_instr = 32'h0;
    m_valid = 1'b0;
    if (m_bc != 32'hFFFF_FFFF) m_bc++;
  endtask
  task automatic model_edge();
    if (m_halted) return;
    if (bus.halt) begin
      m_halted = 1'b1;
      model_bubble();
    end else if (bus.redirect && !bus.stall) begin
      m_pc = bus.redirect_pc;
      m_pending = 1'b0;
      model_bubble();
    end else if (bus.redirect) begin
      m_pend = bus.redirect_pc;
      m_pending = 1'b1;
    end else if (bus.stall) begin
    end else if (m_pending) begin
      m_pc = m_pend;
      m_pending = 1'b0;
      model_bubble();
    end else if (bus.flush) begin
      model_bubble();
      if (bus.ihit) m_pc = m_pc + 32'd4;
    end else if (bus.ihit) begin
      m_instr = bus.imemload;
      m_npc = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_fc != 32'hFFFF_FFFF) m_fc++;
    end else begin
      model_bubble();
    end
  endtask
  task automatic check_model();
    chk("imemaddr", bus.imemaddr, m_pc);
    chk("imemREN", {31'h0, bus.imemREN}, {31'h0, !m_halted});
    chk("ifid_instr", bus.ifid_instr, m_instr);
    chk("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, m_valid});
    if (m_valid) chk("ifid_npc", bus.ifid_npc, m_npc);
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("bubble_cnt", bubble_cnt, m_bc);
`endif
  endtask
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
  endtask
  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_pending = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
    #1;
    chk("reset imemaddr", bus.imemaddr, 32'h0);
    chk("reset imemREN", {31'h0, bus.imemREN}, 32'h1);
    chk("reset ifid_instr", bus.ifid_instr, 32'h0);
    chk("reset ifid_npc", bus.ifid_npc, 32'h0);
    chk("reset ifid_valid", {31'h0, bus.ifid_valid}, 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset fetch_cnt", fetch_cnt, 32'h0);
    chk("reset bubble_cnt", bubble_cnt, 32'h0);
`endif
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    vecs.push_back(mk(1, 32'h2008_0005, 0, 0, 0, 0, 0, 32'h4, 1, 32'h2008_0005, 32'h4, 1));
    vecs.push_back(mk(1, 32'h2008_0005, 0, 0, 0, 0, 0, 32'h8, 1, 32'h2008_0005, 32'h8, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h8, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h8, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h2008_0005, 0, 0, 0, 0, 0, 32'hC, 1, 32'h2008_0005, 32'hC, 1));
    vecs.push_back(mk(1, 32'h9999, 0, 0, 1, 32'h40, 0, 32'h40, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h1111, 0, 0, 0, 0, 0, 32'h44, 1, 32'h1111, 32'h44, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h2222, 1, 1, 1, 32'h100, 0, 32'h44, 1, 32'h1111, 32'h44, 1));
    vecs.push_back(mk(1, 32'h2222, 0, 0, 0, 0, 0, 32'h100, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h2222, 1, 0, 1, 32'h40, 0, 32'h100, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h2222, 1, 0, 1, 32'h80, 0, 32'h100, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h80, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h5555, 0, 1, 0, 0, 0, 32'h84, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 0, 32'h84, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h3333, 0, 0, 0, 0, 0, 32'h88, 1, 32'h3333, 32'h88, 1));
    vecs.push_back(mk(1, 32'h7777, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h4444, 0, 0, 0, 0, 0, 32'h0, 1, 32'h4444, 32'h0, 1));
    vecs.push_back(mk(1, 32'h6666, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h6666, 0, 0, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h6666, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h6666, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    foreach (vecs[k]) begin
      drive(vecs[k].ih, vecs[k].ld, vecs[k].st, vecs[k].fl, vecs[k].rd, vecs[k].rp, vecs[k].ht);
      step();
      chk("vec imemaddr", bus.imemaddr, vecs[k].ea);
      chk("vec imemREN", {31'h0, bus.imemREN}, {31'h0, vecs[k].er});
      chk("vec ifid_instr", bus.ifid_instr, vecs[k].ei);
      chk("vec ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, vecs[k].ev});
      if (vecs[k].ev) chk("vec ifid_npc", bus.ifid_npc, vecs[k].en);
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(i != 2 && i != 4, 32'hA000_0000 + i, 0, 0, 0, 0, 0);
      step();
    end
    chk("hit count pc", bus.imemaddr, 32'd20);
`ifdef FETCH_PERF_EN
    chk("fetch_cnt after 5 hits", fetch_cnt, 32'd5);
    chk("bubble_cnt after 2 misses", bubble_cnt, 32'd2);
`endif
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, rp, $urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
